// File: rtl/fetch_controller.sv
// Instruction fetch controller: loads program bytes, then runs the IF stage.
// Owns the PC, the IF/ID register and the fetch counter.
module fetch_controller #(
    parameter int unsigned MEM_BYTES = 128,
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INST  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Load_Valid,
    input  logic [6:0]  Load_Addr,
    input  logic [7:0]  Load_Data,
    input  logic        Load_Done,
    output logic        Load_Ready,
    output logic        Mem_Wr_En,
    output logic [6:0]  Mem_Wr_Addr,
    output logic [7:0]  Mem_Wr_Data,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    output logic [63:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic [31:0] Fetch_Count
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic        halted_q, halted_d;
    logic        load_ready_q, load_ready_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic        addr_in_range;
    logic [64:0] pc_last_byte;
    logic        pc_past_end;
    logic        halt_fetch;
    logic [63:0] branch_pc;
    logic [1:0]  unused_target_lsb;

    assign addr_in_range = ({25'b0, Load_Addr} < MEM_BYTES);

    // 65-bit sum so a PC near the top of the space cannot wrap below the limit
    assign pc_last_byte = {1'b0, pc_q} + 65'd3;
    assign pc_past_end  = (pc_last_byte >= 65'(MEM_BYTES));
    assign halt_fetch   = pc_past_end || (Instruction == 32'h0);

    assign branch_pc         = {Branch_Target[63:2], 2'b00};
    assign unused_target_lsb = Branch_Target[1:0];

    assign Mem_Wr_En   = (state_q == LOAD) && Load_Valid && addr_in_range;
    assign Mem_Wr_Addr = Load_Addr;
    assign Mem_Wr_Data = Load_Data;

    assign Load_Ready        = load_ready_q;
    assign Inst_Address      = pc_q;
    assign IF_ID_PC          = if_pc_q;
    assign IF_ID_Instruction = if_inst_q;
    assign IF_ID_Valid       = if_valid_q;
    assign Halted            = halted_q;
    assign Fetch_Count       = fetch_cnt_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        if_pc_d      = if_pc_q;
        if_inst_d    = if_inst_q;
        if_valid_d   = if_valid_q;
        halted_d     = halted_q;
        load_ready_d = load_ready_q;
        fetch_cnt_d  = fetch_cnt_q;

        unique case (state_q)
            LOAD: begin
                if (Load_Done) begin
                    state_d      = RUN;
                    pc_d         = RESET_PC;
                    load_ready_d = 1'b0;
                end
            end
            RUN: begin
                if (Branch_Taken) begin
                    pc_d       = branch_pc;
                    if_inst_d  = NOP_INST;
                    if_valid_d = 1'b0;
                end else if (!Stall) begin
                    if (halt_fetch) begin
                        state_d    = HALT;
                        halted_d   = 1'b1;
                        if_inst_d  = NOP_INST;
                        if_valid_d = 1'b0;
                    end else begin
                        pc_d       = pc_q + 64'd4;
                        if_pc_d    = pc_q;
                        if_inst_d  = Instruction;
                        if_valid_d = 1'b1;
                        if (fetch_cnt_q != 32'hFFFF_FFFF) begin
                            fetch_cnt_d = fetch_cnt_q + 32'd1;
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOAD;
            pc_q         <= RESET_PC;
            if_pc_q      <= 64'h0;
            if_inst_q    <= NOP_INST;
            if_valid_q   <= 1'b0;
            halted_q     <= 1'b0;
            load_ready_q <= 1'b1;
            fetch_cnt_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            if_pc_q      <= if_pc_d;
            if_inst_q    <= if_inst_d;
            if_valid_q   <= if_valid_d;
            halted_q     <= halted_d;
            load_ready_q <= load_ready_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: byte memory, reference model of the fetch rules,
// per-cycle comparison plus directed literal checks.
module tb_fetch_controller;

    localparam int          MEMB = 100;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Load_Valid = 1'b0;
    logic [6:0]  Load_Addr = '0;
    logic [7:0]  Load_Data = '0;
    logic        Load_Done = 1'b0;
    logic        Load_Ready;
    logic        Mem_Wr_En;
    logic [6:0]  Mem_Wr_Addr;
    logic [7:0]  Mem_Wr_Data;
    logic [63:0] Inst_Address;
    logic [31:0] Instruction;
    logic        Stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [63:0] Branch_Target = '0;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_Valid;
    logic        Halted;
    logic [31:0] Fetch_Count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    fetch_controller #(.MEM_BYTES(MEMB)) dut (
        .clk(clk), .reset(rst_n),
        .Load_Valid(Load_Valid), .Load_Addr(Load_Addr),
        .Load_Data(Load_Data), .Load_Done(Load_Done),
        .Load_Ready(Load_Ready), .Mem_Wr_En(Mem_Wr_En),
        .Mem_Wr_Addr(Mem_Wr_Addr), .Mem_Wr_Data(Mem_Wr_Data),
        .Inst_Address(Inst_Address), .Instruction(Instruction),
        .Stall(Stall), .Branch_Taken(Branch_Taken),
        .Branch_Target(Branch_Target), .IF_ID_PC(IF_ID_PC),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_Valid(IF_ID_Valid),
        .Halted(Halted), .Fetch_Count(Fetch_Count)
    );

    always #5 clk = ~clk;

    // Physical memory written through the DUT's write port
    logic [7:0] phys_mem [128];
    // Model's own view of what memory should contain
    logic [7:0] ref_mem  [128];

    always @(posedge clk) begin
        if (Mem_Wr_En === 1'b1) phys_mem[Mem_Wr_Addr] <= Mem_Wr_Data;
    end

    function automatic logic [31:0] phys_word(input logic [63:0] a);
        if (a < 64'(MEMB - 3)) begin
            int i = int'(a);
            return {phys_mem[i+3], phys_mem[i+2], phys_mem[i+1], phys_mem[i]};
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_word(input logic [63:0] a);
        if (a < 64'(MEMB - 3)) begin
            int i = int'(a);
            return {ref_mem[i+3], ref_mem[i+2], ref_mem[i+1], ref_mem[i]};
        end
        return 32'h0;
    endfunction

    assign Instruction = phys_word(Inst_Address);

    typedef enum {M_LOAD, M_RUN, M_HALT} mode_t;
    mode_t       m_mode = M_LOAD;
    logic [63:0] m_pc = '0;
    logic [63:0] m_ifpc = '0;
    logic [31:0] m_ifinst = NOP;
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode   <= M_LOAD;
            m_pc     <= '0;
            m_ifpc   <= '0;
            m_ifinst <= NOP;
            m_valid  <= 1'b0;
            m_cnt    <= '0;
        end else if (m_mode == M_LOAD) begin
            if (Load_Valid && int'(Load_Addr) < MEMB) ref_mem[Load_Addr] <= Load_Data;
            if (Load_Done) begin
                m_mode <= M_RUN;
                m_pc   <= '0;
            end
        end else if (m_mode == M_RUN) begin
            if (Branch_Taken) begin
                m_pc     <= Branch_Target & ~64'd3;
                m_ifinst <= NOP;
                m_valid  <= 1'b0;
            end else if (!Stall) begin
                if (!(m_pc < 64'(MEMB - 3)) || ref_word(m_pc) == 32'h0) begin
                    m_mode   <= M_HALT;
                    m_ifinst <= NOP;
                    m_valid  <= 1'b0;
                end else begin
                    m_ifpc   <= m_pc;
                    m_ifinst <= ref_word(m_pc);
                    m_valid  <= 1'b1;
                    m_pc     <= m_pc + 64'd4;
                    m_cnt    <= (m_cnt == 32'hFFFF_FFFF) ? m_cnt : m_cnt + 32'd1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_wr;
            exp_wr = (m_mode == M_LOAD) && Load_Valid && int'(Load_Addr) < MEMB;
            chk("load_ready", 64'(Load_Ready), 64'(m_mode == M_LOAD));
            chk("mem_wr_en", 64'(Mem_Wr_En), 64'(exp_wr));
            if (exp_wr) begin
                chk("mem_wr_addr", 64'(Mem_Wr_Addr), 64'(Load_Addr));
                chk("mem_wr_data", 64'(Mem_Wr_Data), 64'(Load_Data));
            end
            chk("inst_address", Inst_Address, m_pc);
            chk("if_id_pc", IF_ID_PC, m_ifpc);
            chk("if_id_inst", 64'(IF_ID_Instruction), 64'(m_ifinst));
            chk("if_id_valid", 64'(IF_ID_Valid), 64'(m_valid));
            chk("halted", 64'(Halted), 64'(m_mode == M_HALT));
            chk("fetch_count", 64'(Fetch_Count), 64'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        Load_Valid = 0; Load_Done = 0; Stall = 0; Branch_Taken = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    task automatic load_byte(input int a, input logic [7:0] d);
        Load_Valid = 1; Load_Addr = 7'(a); Load_Data = d;
        step();
        Load_Valid = 0;
    endtask

    task automatic finish_load();
        Load_Done = 1;
        step();
        Load_Done = 0;
    endtask

    initial begin
        logic [7:0] prog [4];
        for (int i = 0; i < 128; i++) begin
            phys_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        rst_n = 0;
        #1;
        chk_en = 1;
        do_reset();
        chk("rst_ready", 64'(Load_Ready), 64'd1);
        chk("rst_pc", Inst_Address, 64'd0);
        chk("rst_inst", 64'(IF_ID_Instruction), 64'h13);
        chk("rst_count", 64'(Fetch_Count), 64'd0);

        // Program: first word 40D58533, nonzero words to 15, zero at 16
        prog = '{8'h33, 8'h85, 8'hD5, 8'h40};
        for (int i = 0; i < 4; i++) load_byte(i, prog[i]);
        for (int i = 4; i < 16; i++) load_byte(i, 8'(i + 1));
        for (int i = 32; i < 40; i++) load_byte(i, 8'h11);
        finish_load();
        step();
        chk("first_inst", 64'(IF_ID_Instruction), 64'h40D58533);
        chk("first_pc", IF_ID_PC, 64'd0);
        chk("first_valid", 64'(IF_ID_Valid), 64'd1);
        chk("first_next", Inst_Address, 64'd4);
        step();
        Stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", Inst_Address, 64'd8);
            chk("stall_ifpc", IF_ID_PC, 64'd4);
            chk("stall_cnt", 64'(Fetch_Count), 64'd2);
        end
        Stall = 0;
        step();
        Stall = 1; Branch_Taken = 1; Branch_Target = 64'h51;
        step();
        idle_in();
        chk("br_pc", Inst_Address, 64'h50);
        chk("br_valid", 64'(IF_ID_Valid), 64'd0);
        chk("br_inst", 64'(IF_ID_Instruction), 64'h13);
        chk("br_cnt", 64'(Fetch_Count), 64'd3);

        // Rerun the same program from reset to reach the zero word
        do_reset();
        finish_load();
        for (int i = 0; i < 5; i++) step();
        chk("halt_flag", 64'(Halted), 64'd1);
        chk("halt_pc", Inst_Address, 64'd16);
        chk("halt_valid", 64'(IF_ID_Valid), 64'd0);
        chk("halt_cnt", 64'(Fetch_Count), 64'd4);
        Load_Valid = 1; Load_Addr = 7'd20; Load_Data = 8'hFF;
        #1;
        chk("halt_no_wr", 64'(Mem_Wr_En), 64'd0);
        step();
        idle_in();
        chk("halt_stays", 64'(Halted), 64'd1);

        do_reset();
        Load_Valid = 1; Load_Addr = 7'd127; Load_Data = 8'h55;
        #1;
        chk("oob_drop", 64'(Mem_Wr_En), 64'd0);
        step();
        Load_Addr = 7'd50; Load_Data = 8'hAB; Load_Done = 1;
        #1;
        chk("done_wr", 64'(Mem_Wr_En), 64'd1);
        step();
        idle_in();
        chk("done_run", 64'(Load_Ready), 64'd0);
        chk("done_byte", 64'(phys_mem[50]), 64'hAB);
        Branch_Taken = 1; Branch_Target = 64'h20;
        step();
        Branch_Taken = 0;
        step();
        chk("pc_24", Inst_Address, 64'h24);
        #2;
        rst_n = 0;
        #1;
        chk("arst_pc", Inst_Address, 64'd0);
        chk("arst_ifpc", IF_ID_PC, 64'd0);
        chk("arst_inst", 64'(IF_ID_Instruction), 64'h13);
        chk("arst_valid", 64'(IF_ID_Valid), 64'd0);
        chk("arst_cnt", 64'(Fetch_Count), 64'd0);
        chk("arst_halt", 64'(Halted), 64'd0);
        chk("arst_ready", 64'(Load_Ready), 64'd1);
        step();
        rst_n = 1;

        for (int e = 0; e < 30; e++) begin
            int nload;
            do_reset();
            nload = int'($urandom_range(4, 40));
            for (int i = 0; i < nload; i++) begin
                Load_Valid = ($urandom % 4) != 0;
                Load_Addr  = 7'($urandom_range(0, 127));
                Load_Data  = ($urandom % 16 == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                Load_Done  = (i == nload - 1);
                step();
            end
            idle_in();
            for (int c = 0; c < 60; c++) begin
                Stall         = ($urandom % 4) == 0;
                Branch_Taken  = ($urandom % 10) == 0;
                Branch_Target = ($urandom % 8 == 0) ? {$urandom, $urandom}
                                                    : 64'($urandom_range(0, 110));
                Load_Valid    = ($urandom % 3) == 0;
                Load_Addr     = 7'($urandom_range(0, 127));
                Load_Data     = 8'($urandom);
                Load_Done     = ($urandom % 8) == 0;
                step();
            end
            idle_in();
            if (e % 3 == 0) begin
                #3;
                rst_n = 0;
                #1;
                chk("rand_arst_pc", Inst_Address, 64'd0);
                chk("rand_arst_valid", 64'(IF_ID_Valid), 64'd0);
                step();
            end
        end

        idle_in();
        step();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Parameters
REQ-001 SHALL have parameter MEM_BYTES, default 128: instruction memory size in bytes.
REQ-002 SHALL have parameter RESET_PC, default 64'h0: first fetch address after load.
REQ-003 SHALL have parameter NOP_INST, default 32'h00000013: bubble encoding (addi x0,x0,0).

Interface
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port Load_Valid, input, 1: loader presents one instruction byte.
REQ-007 SHALL have port Load_Addr, input, 7: byte address of the loader write.
REQ-008 SHALL have port Load_Data, input, 8: loader byte.
REQ-009 SHALL have port Load_Done, input, 1: single-cycle pulse ending the load phase.
REQ-010 SHALL have port Load_Ready, output, 1: block is in LOAD and accepts bytes.
REQ-011 SHALL have port Mem_Wr_En, Mem_Wr_Addr, Mem_Wr_Data, outputs, 1/7/8: memory write port.
REQ-012 SHALL have port Inst_Address, output, 64: fetch address driven to the memory read port.
REQ-013 SHALL have port Instruction, input, 32: combinational memory read data for Inst_Address.
REQ-014 SHALL have port Stall, input, 1: hazard unit holds fetch.
REQ-015 SHALL have port Branch_Taken, input, 1, and port Branch_Target, input, 64: redirect request.
REQ-016 SHALL have port IF_ID_PC, output, 64, and port IF_ID_Instruction, output, 32: IF/ID register.
REQ-017 SHALL have port IF_ID_Valid, output, 1: IF/ID contents are a real instruction.
REQ-018 SHALL have port Halted, output, 1, and port Fetch_Count, output, 32: status.

Function
REQ-019 SHALL implement FSM states LOAD, RUN, HALT; reset enters LOAD.
REQ-020 In LOAD, Load_Ready SHALL be 1; Mem_Wr_En SHALL equal Load_Valid combinationally, with Mem_Wr_Addr/Mem_Wr_Data passing Load_Addr/Load_Data.
REQ-021 Load_Addr >= MEM_BYTES SHALL be dropped: Mem_Wr_En stays 0.
REQ-022 Load_Done in LOAD SHALL move to RUN next edge with PC <= RESET_PC; a byte with Load_Valid in the same cycle SHALL still be written.
REQ-023 Outside LOAD, Load_Ready and Mem_Wr_En SHALL be 0; Load_Valid and Load_Done SHALL be ignored.
REQ-024 Inst_Address SHALL equal the PC register in all states.
REQ-025 In RUN with Stall=0 and Branch_Taken=0: IF_ID <= {PC, Instruction}, IF_ID_Valid <= 1, PC <= PC+4 (64-bit wrap), Fetch_Count += 1.
REQ-026 In RUN with Branch_Taken=1, regardless of Stall: PC <= {Branch_Target[63:2], 2'b00}, IF_ID_Instruction <= NOP_INST, IF_ID_Valid <= 0, IF_ID_PC unchanged, Fetch_Count unchanged.
REQ-027 In RUN with Stall=1 and Branch_Taken=0: PC, IF_ID registers, and Fetch_Count SHALL hold.
REQ-028 In RUN with no stall and no branch, Instruction == 32'h0 or PC+3 >= MEM_BYTES SHALL enter HALT next edge: IF_ID_Valid <= 0, IF_ID_Instruction <= NOP_INST, PC holds.
REQ-029 Branch_Taken SHALL take priority over the halt condition in REQ-028.
REQ-030 HALT SHALL be exited only by reset; Halted SHALL be 1 only in HALT; PC, IF_ID, and Fetch_Count SHALL hold there.
REQ-031 Fetch_Count SHALL saturate at 32'hFFFFFFFF.
REQ-032 In LOAD, IF_ID_Valid SHALL be 0 and PC SHALL hold RESET_PC.

Reset
REQ-033 Reset assertion SHALL act immediately, at any state and mid-fetch or mid-load.
REQ-034 Reset SHALL set: state LOAD, PC = RESET_PC, IF_ID_PC = 0, IF_ID_Instruction = NOP_INST, IF_ID_Valid = 0, Fetch_Count = 0, Halted = 0.
REQ-035 Memory contents SHALL NOT be cleared by this block.

Verification
REQ-036 Load bytes 33,85,D5,40 to addresses 0-3, pulse Load_Done, then clock once -> IF_ID_Instruction = 40D58533, IF_ID_PC = 0, IF_ID_Valid = 1, Inst_Address = 4.
REQ-037 RUN at PC = 8 with Stall = 1 for 3 cycles -> PC = 8 and IF_ID unchanged throughout; Fetch_Count unchanged.
REQ-038 Branch_Taken = 1 and Stall = 1 at PC = 12 with Branch_Target = 0x51 -> next PC = 0x50, IF_ID_Valid = 0, IF_ID_Instruction = 00000013.
REQ-039 Fetch of a word equal to 0 at PC = 16 -> Halted = 1 next edge, PC stays 16, IF_ID_Valid = 0; later Load_Valid is ignored.
REQ-040 Load_Addr = 127 with MEM_BYTES = 100 -> Mem_Wr_En = 0; Load_Valid and Load_Done in the same cycle -> byte written and state = RUN.
REQ-041 Assert reset while in RUN at PC = 0x24 -> all outputs at REQ-034 values immediately, before the next clock edge, and Load_Ready = 1.
